// File: rtl/oni16_pkg.sv
// -----------------------------------------------------------------------------
// oni16_pkg
// Shared definitions for the Oni16 stack controller:
//   - state_e        : controller FSM states (IDLE, WRITE, READ, RESP)
//   - ERR_UNDERFLOW  : err_flags bit set by a POP on an empty stack
//   - ERR_OVERFLOW   : err_flags bit set by a PUSH on a full stack
//   - DEF_STACK_TOP / DEF_STACK_BOTTOM : default stack byte-address bounds
//   - DATA_W / ADDR_W : data-memory port widths
// -----------------------------------------------------------------------------
package oni16_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_OVERFLOW  = 1;

    localparam logic [ADDR_W-1:0] DEF_STACK_TOP    = 16'h9FFF;
    localparam logic [ADDR_W-1:0] DEF_STACK_BOTTOM = 16'h9000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/oni16_stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// oni16_stack_ctrl_if
// Bundles the command, response, data-memory and status signals of the stack
// controller.
//   slave  : the controller (accepts commands, drives memory requests/status)
//   master : its environment (execute stage, memory port, error clear)
// Signal groups:
//   cmd_valid/cmd_ready/cmd_push/cmd_data   : command handshake
//   rsp_valid/rsp_data/rsp_err              : one-cycle completion response
//   mem_req/mem_we/mem_addr/mem_wdata/
//   mem_rdata/mem_ack                       : req/ack byte memory port
//   sp/empty/full/err_flags/err_clr         : stack status and sticky errors
// -----------------------------------------------------------------------------
interface oni16_stack_ctrl_if;
    import oni16_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_push;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic [ADDR_W-1:0] sp;
    logic              empty;
    logic              full;
    logic [1:0]        err_flags;
    logic              err_clr;

    modport slave (
        input  cmd_valid, cmd_push, cmd_data, mem_rdata, mem_ack, err_clr,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
               mem_req, mem_we, mem_addr, mem_wdata,
               sp, empty, full, err_flags
    );

    modport master (
        output cmd_valid, cmd_push, cmd_data, mem_rdata, mem_ack, err_clr,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
               mem_req, mem_we, mem_addr, mem_wdata,
               sp, empty, full, err_flags
    );

endinterface

// File: rtl/oni16_stack_ctrl.sv
// -----------------------------------------------------------------------------
// oni16_stack_ctrl
// Stack controller for the Oni16 core. Turns PUSH/POP commands from the
// execute stage into single-byte transactions on the shared req/ack data-memory
// port, owns the full-descending stack pointer, bounds-checks every command
// before touching memory and keeps sticky underflow/overflow flags.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : oni16_stack_ctrl_if.slave (command, response, memory, status)
// Parameters:
//   STACK_TOP    : highest stack byte address (empty sp is STACK_TOP+1)
//   STACK_BOTTOM : lowest stack byte address (sp here means full)
// -----------------------------------------------------------------------------
module oni16_stack_ctrl
    import oni16_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_TOP    = DEF_STACK_TOP,
    parameter logic [ADDR_W-1:0] STACK_BOTTOM = DEF_STACK_BOTTOM
) (
    input  logic              clk,
    input  logic              reset,
    oni16_stack_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] SP_EMPTY = STACK_TOP + 16'd1;

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] sp_q,        sp_d;
    logic [1:0]        err_q,       err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic is_empty;
    logic is_full;
    logic cmd_accept;

    assign is_empty   = (sp_q == SP_EMPTY);
    assign is_full    = (sp_q == STACK_BOTTOM);
    assign cmd_accept = cmd_ready_q && bus.cmd_valid;

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        // Clear drops every flag; a new error below re-sets its own bit, so
        // the set wins for that bit only.
        err_d       = bus.err_clr ? 2'b00 : err_q;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        // Address and write byte hold their values while a request waits.
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (bus.cmd_push) begin
                        if (is_full) begin
                            err_d[ERR_OVERFLOW] = 1'b1;
                            rsp_err_d           = 1'b1;
                            state_d             = RESP;
                        end else begin
                            mem_addr_d  = sp_q - 16'd1;
                            mem_wdata_d = bus.cmd_data;
                            state_d     = WRITE;
                        end
                    end else begin
                        if (is_empty) begin
                            err_d[ERR_UNDERFLOW] = 1'b1;
                            rsp_err_d            = 1'b1;
                            state_d              = RESP;
                        end else begin
                            mem_addr_d = sp_q;
                            state_d    = READ;
                        end
                    end
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    sp_d    = sp_q - 16'd1;
                    state_d = RESP;
                end
            end
            READ: begin
                if (bus.mem_ack) begin
                    rsp_data_d = bus.mem_rdata;
                    sp_d       = sp_q + 16'd1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Memory-port outputs are registered from the next state so they are
        // glitch-free and idle at zero outside a transaction.
        if (state_d != WRITE && state_d != READ) begin
            mem_addr_d = '0;
        end
        if (state_d != WRITE) begin
            mem_wdata_d = '0;
        end
        mem_req_d   = (state_d == WRITE) || (state_d == READ);
        mem_we_d    = (state_d == WRITE);
        rsp_valid_d = (state_d == RESP);
        cmd_ready_d = (state_d == IDLE);
    end

    // Every register is cleared asynchronously so an in-flight memory request
    // is withdrawn the moment reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sp_q        <= SP_EMPTY;
            err_q       <= 2'b00;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.sp        = sp_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.err_flags = err_q;

endmodule

// File: tb/tb_oni16_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oni16_stack_ctrl
// Directed plus randomized bench for oni16_stack_ctrl. The reference is a
// byte queue holding the stack contents; expected sp, addresses, flags and
// popped bytes all follow from its depth and order. A small byte array plays
// the data memory the controller writes and reads.
// -----------------------------------------------------------------------------
module tb_oni16_stack_ctrl;

    logic clk;
    logic reset;

    oni16_stack_ctrl_if bus();

    oni16_stack_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] model[$];
    logic [1:0] exp_err;
    logic [7:0] mem [0:4095];
    logic [7:0] last_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_sp();
        return 16'hA000 - 16'(model.size());
    endfunction

    // Idle-state checks; called at a falling edge while the controller idles.
    task automatic chk_idle();
        chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
        chk("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("idle_sp", 32'(bus.sp), 32'(exp_sp()));
        chk("idle_empty", 32'(bus.empty), 32'(model.size() == 0));
        chk("idle_full", 32'(bus.full), 32'(model.size() == 4096));
        chk("idle_err", 32'(bus.err_flags), 32'(exp_err));
    endtask

    // One command, entered and left at a falling edge with the controller idle.
    task automatic do_cmd(input bit push, input logic [7:0] d, input int dly, input bit clr);
        bit          is_err;
        logic [15:0] exp_addr;
        logic [7:0]  exp_rd;
        is_err   = push ? (model.size() == 4096) : (model.size() == 0);
        exp_addr = push ? (exp_sp() - 16'd1) : exp_sp();
        exp_rd   = 8'h00;

        bus.cmd_valid = 1'b1;
        bus.cmd_push  = push;
        bus.cmd_data  = d;
        bus.err_clr   = clr;
        @(posedge clk);
        if (clr) exp_err = 2'b00;
        if (is_err) exp_err[push ? 1 : 0] = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.err_clr   = 1'b0;
        bus.cmd_data  = 8'($urandom);
        chk("err_flags", 32'(bus.err_flags), 32'(exp_err));

        if (is_err) begin
            chk("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("err_rsp_err", 32'(bus.rsp_err), 32'd1);
            chk("err_rsp_data", 32'(bus.rsp_data), 32'd0);
            chk("err_mem_req", 32'(bus.mem_req), 32'd0);
            chk("err_ready", 32'(bus.cmd_ready), 32'd0);
            chk("err_sp", 32'(bus.sp), 32'(exp_sp()));
        end else begin
            for (int c = 0; c <= dly; c++) begin
                chk("req", 32'(bus.mem_req), 32'd1);
                chk("we", 32'(bus.mem_we), 32'(push));
                chk("addr", 32'(bus.mem_addr), 32'(exp_addr));
                chk("wdata", 32'(bus.mem_wdata), push ? 32'(d) : 32'd0);
                chk("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                if (c == dly) begin
                    bus.mem_ack = 1'b1;
                    if (push) begin
                        mem[exp_addr[11:0]] = bus.mem_wdata;
                        bus.mem_rdata = 8'($urandom);
                    end else begin
                        bus.mem_rdata = mem[exp_addr[11:0]];
                    end
                end else begin
                    bus.mem_rdata = 8'($urandom);
                end
                @(negedge clk);
            end
            bus.mem_ack = 1'b0;
            if (push) model.push_back(d);
            else      exp_rd = model.pop_back();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_err", 32'(bus.rsp_err), 32'd0);
            chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rd));
            chk("rsp_mem_req", 32'(bus.mem_req), 32'd0);
            chk("rsp_ready", 32'(bus.cmd_ready), 32'd0);
            chk("rsp_sp", 32'(bus.sp), 32'(exp_sp()));
        end
        @(negedge clk);
        chk_idle();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_push  = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.mem_rdata = 8'h00;
        bus.mem_ack   = 1'b0;
        bus.err_clr   = 1'b0;
        exp_err       = 2'b00;
        last_byte     = 8'h00;
        reset         = 1'b1;
        #1 reset = 1'b0;
        #2;
        // Reset values, sampled while reset is held
        chk("rst_sp", 32'(bus.sp), 32'h0000A000);
        chk("rst_err", 32'(bus.err_flags), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle();

        // POP on an empty stack
        do_cmd(1'b0, 8'h00, 0, 1'b0);
        // PUSH 5A with ack in the request cycle, then pop it back
        do_cmd(1'b1, 8'h5A, 0, 1'b0);
        do_cmd(1'b0, 8'h00, 1, 1'b0);
        // LIFO order with delayed acks
        do_cmd(1'b1, 8'h11, 3, 1'b0);
        do_cmd(1'b1, 8'h22, 3, 1'b0);
        do_cmd(1'b0, 8'h00, 3, 1'b0);
        do_cmd(1'b0, 8'h00, 3, 1'b0);
        // Clear in the same cycle as an underflow, then clear alone
        do_cmd(1'b0, 8'h00, 0, 1'b1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        exp_err = 2'b00;
        chk("clr_alone", 32'(bus.err_flags), 32'd0);

        // Fill the whole stack, then overflow
        for (int i = 0; i < 4096; i++) begin
            last_byte = 8'($urandom);
            do_cmd(1'b1, last_byte, int'($urandom_range(0, 1)), 1'b0);
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_sp", 32'(bus.sp), 32'h00009000);
        do_cmd(1'b1, 8'hEE, 0, 1'b0);
        chk("ovf_flag", 32'(bus.err_flags[1]), 32'd1);
        // Underflow flag set earlier, then overflow alone with clear
        do_cmd(1'b0, 8'h00, 0, 1'b0);
        chk("pop_after_full", 32'(bus.rsp_data), 32'd0);
        do_cmd(1'b1, last_byte, 0, 1'b0);
        do_cmd(1'b1, 8'h77, 0, 1'b1);

        // Random traffic near the full boundary
        for (int i = 0; i < 150; i++) begin
            do_cmd(bit'($urandom_range(0, 1) != 0 || model.size() < 4090), 8'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 7) == 0));
        end

        // Reset while a READ waits for its ack
        do_cmd(1'b1, 8'hC3, 0, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_push  = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("mid_read_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        chk("mid_read_hold", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_drop_req", 32'(bus.mem_req), 32'd0);
        chk("rst_drop_sp", 32'(bus.sp), 32'h0000A000);
        chk("rst_drop_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("rst_hold_rsp", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b1;
        model.delete();
        exp_err = 2'b00;
        @(negedge clk);
        chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        chk_idle();
        do_cmd(1'b1, 8'h3C, 1, 1'b0);

        // Random traffic near the empty boundary
        for (int i = 0; i < 300; i++) begin
            do_cmd(bit'($urandom_range(0, 1)), 8'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oni16_stack_ctrl.md
# oni16_stack_ctrl

Stack controller for the Oni16 core. It turns PUSH/POP commands from the execute stage into single-byte transactions on the shared data-memory port. It owns the stack pointer, checks stack bounds before any memory access and keeps sticky stack error flags. It sits between the execute stage and the memory port, so the core never drives stack addresses itself.

## Interface
- STACK_TOP, 16'h9FFF, highest stack byte address
- STACK_BOTTOM, 16'h9000, lowest stack byte address
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered by execute stage
- cmd_ready  out  1  controller can accept a command
- cmd_push  in  1  1 = PUSH, 0 = POP
- cmd_data  in  8  byte to push; ignored for POP
- rsp_valid  out  1  one-cycle pulse: command finished
- rsp_data  out  8  popped byte; valid with rsp_valid on a good POP, otherwise 0
- rsp_err  out  1  command rejected (bounds), valid with rsp_valid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  16  byte address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, sampled on the cycle mem_ack = 1
- mem_ack  in  1  transaction complete this cycle
- sp  out  16  current stack pointer
- empty  out  1  sp == STACK_TOP+1
- full  out  1  sp == STACK_BOTTOM
- err_flags  out  2  sticky: bit0 UNDERFLOW, bit1 OVERFLOW
- err_clr  in  1  clears err_flags

## Operation
- Stack model:
  - Full-descending: sp points at the last pushed byte.
  - Empty when sp == STACK_TOP+1 (16'hA000 at default).
  - Reset sp = STACK_TOP+1.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - cmd_ready = 1. A command is accepted when cmd_valid && cmd_ready.
  - PUSH while full: no memory access; set err_flags[1]; latch rsp_err = 1; go to RESP.
  - POP while empty: no memory access; set err_flags[0]; latch rsp_err = 1; go to RESP.
  - PUSH otherwise: latch cmd_data; go to WRITE.
  - POP otherwise: go to READ.
- WRITE:
  - Drives mem_req = 1, mem_we = 1, mem_addr = sp-1, mem_wdata = latched byte.
  - All four are held stable until mem_ack.
  - On mem_ack: sp <= sp-1; go to RESP.
- READ:
  - Drives mem_req = 1, mem_we = 0, mem_addr = sp, held until mem_ack.
  - On mem_ack: latch mem_rdata into rsp_data; sp <= sp+1; go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle; cmd_ready = 0; next state IDLE.
- Outside WRITE/READ: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- sp is 16-bit unsigned. It never leaves [STACK_BOTTOM, STACK_TOP+1], so no wrap-around is possible.
- err_clr and a new error in the same cycle: the set wins for the new bit; other bits clear.
- A mem_ack outside WRITE/READ is ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert by system):
  - state = IDLE, sp = STACK_TOP+1, err_flags = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cmd_ready = 1 from the first clock after reset deasserts.
- Reset during WRITE/READ: the request is dropped immediately and the transaction is abandoned; no response is issued.
- Latency, command accepted in cycle 0:
  - Bounds error: rsp_valid in cycle 1.
  - Memory op with mem_ack in cycle k (k ≥ 1): rsp_valid in cycle k+1.
  - Best case is therefore rsp_valid in cycle 2.
- Throughput: one command per 2 cycles (error) or 3+ cycles (memory op).
- sp, empty and full update on the cycle after mem_ack and are stable while cmd_ready = 1.

## Structure
- Shared package oni16_pkg holds:
  - the state enum (IDLE, WRITE, READ, RESP);
  - the error bit indices ERR_UNDERFLOW = 0 and ERR_OVERFLOW = 1;
  - the default stack bounds.
- Single flat module; no sub-module is warranted.
- The memory port is plain req/ack, so an external arbiter can share it with instruction fetch.

## Test plan
- Reset, then POP -> rsp_valid in cycle 1, rsp_err = 1, err_flags = 2'b01, no mem_req, sp = 16'hA000.
- PUSH 8'h5A with ack in the same cycle as the request -> mem_addr = 16'h9FFF, mem_we = 1, mem_wdata = 8'h5A; rsp_valid 2 cycles after accept; sp = 16'h9FFF.
- PUSH 8'h11, then PUSH 8'h22, then POP, then POP (ack delayed 3 cycles each) -> pops return 8'h22 then 8'h11; sp ends at 16'hA000; request signals held stable while waiting for ack.
- Fill 4096 bytes (sp = 16'h9000, full = 1), then PUSH -> rsp_err = 1, err_flags[1] = 1, no mem_req; a following POP returns the last pushed byte.
- err_clr in the same cycle as an underflow error -> err_flags = 2'b01 afterwards; err_clr alone -> err_flags = 0.
- reset asserted mid-READ while ack is pending -> mem_req drops at once, sp = 16'hA000, no rsp_valid; the next PUSH proceeds normally.
